path_rr: RTL
============

Name: path_rr

Overview:
- N-master generalisation of the team's two-master arbitrated path.
- Merges NCH valid/stop source channels into one req/gnt output port, through an internal FIFO with a bypass path for the empty-FIFO case.
- Arbitration is work-conserving round-robin with a configurable burst quantum per ownership slot.
- Every output beat carries the ID of its source channel; FIFO occupancy is exported.
- Sits between traffic masters and a single shared downstream consumer.

Parameters:
- DWIDTH, 8: data width per channel.
- FDEPTH, 8: FIFO depth in entries (≥2, any integer).
- NCH, 4: number of source channels (≥2).
- QUANTUM, 10: maximum accepted beats per ownership slot before forced rotation (≥1).
- CHW, $clog2(NCH): derived channel-ID width. Local, not overridable.
- LW, $clog2(FDEPTH+1): derived occupancy width. Local, not overridable.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_i, input, NCH*DWIDTH: channel k occupies bits [k*DWIDTH +: DWIDTH].
- valid_i, input, NCH: per-channel valid.
- stop_o, output, NCH: per-channel stop (backpressure). Combinational.
- req_o, output, 1: request to the downstream arbiter. Registered.
- gnt_i, input, 1: downstream grant.
- data_o, output, DWIDTH: output data. Registered.
- ch_o, output, CHW: source channel of data_o. Registered.
- valid_o, output, 1: data_o/ch_o valid. Registered.
- level_o, output, LW: FIFO occupancy. Registered.

Behaviour:
- Reset (async, rst_n low): own=0, cnt=0, FIFO empty, req_o=0, valid_o=0, data_o=0, ch_o=0, level_o=0. Reset mid-transfer discards FIFO contents with no drain.
- Combinational terms:
  - stop_o[k]=1 for every k≠own; stop_o[own]=full & ~gnt_i.
  - accept=valid_i[own] & ~stop_o[own].
  - empty=(level==0); full=(level==FDEPTH).
  - bypass=empty & gnt_i & accept.
  - write=accept & ~bypass.
  - read=gnt_i & ~empty.
- FIFO:
  - Each entry stores {own, data}, entry width DWIDTH+CHW, first-in first-out, pointers wrap modulo FDEPTH.
  - Read and write in the same cycle are legal when full; level is unchanged.
  - Write never occurs while empty with gnt_i high, because bypass takes that beat.
- Output, one-cycle latency:
  - valid_o <= read | bypass.
  - If bypass: data_o <= owner data, ch_o <= own.
  - Else if read: data_o, ch_o <= FIFO head.
  - Otherwise data_o and ch_o hold their previous values.
  - level_o <= next level.
- req_o <= (|valid_i) | (next level != 0).
- Arbitration, evaluated each cycle:
  - nxt = first index j in own+1, own+2, … (mod NCH, excluding own) with valid_i[j]=1. If no such j, nxt=(own+1) mod NCH.
  - If accept and cnt==QUANTUM-1: own<=nxt, cnt<=0. Rotation happens even if own is still valid, provided another channel is valid. If no other channel is valid, own holds and cnt<=0.
  - Else if accept: cnt<=cnt+1.
  - Else if ~valid_i[own] and (|valid_i): own<=nxt, cnt<=0 (idle-owner skip).
  - Else: hold own and cnt. This covers owner valid but stalled by full & ~gnt_i.
  - cnt counts accepted beats only, not cycles.
- The switch takes effect next cycle. The new owner sees stop_o[new]=0 no earlier than one cycle after the switch condition.
- Source-side beats are never lost or duplicated: a beat transfers exactly when valid_i[k] & ~stop_o[k].

Decomposition:
- Package path_pkg: function rr_next(own, valid_vec) returning CHW bits. No typedefs are needed beyond it.
- One sub-module: path_fifo (parameters WIDTH, DEPTH). Ports: clk, rst_n, wdata, write_i, read_i, rdata (head, combinational), full_o, empty_o, level_o.
- Arbitration, bypass and output registers stay in path_rr.

Test Plan:
(Defaults throughout: NCH=4, QUANTUM=10, FDEPTH=8, DWIDTH=8.)
- Bypass, single channel:
  - Stimulus: ch0 only valid, data 0x01..0x05, gnt_i=1 throughout.
  - Required: level_o stays 0; valid_o=1 one cycle after each beat; data_o 0x01..0x05 in order; ch_o=0; req_o=1 from the cycle after valid rises.
- Quantum rotation:
  - Stimulus: ch0 and ch2 continuously valid, gnt_i=1.
  - Required: exactly 10 beats with ch_o=0, then 10 with ch_o=2, alternating. ch1 and ch3 are never selected; stop_o[0]=1 during ch2 slots.
- Idle skip:
  - Stimulus: own=0, ch0 drops valid while ch3 is valid.
  - Required: own=3 on the next cycle; cnt restarts at 0; ch3 gets a full 10 beats.
- Fill and stall:
  - Stimulus: ch1 valid, gnt_i=0 for 12 cycles.
  - Required: 8 beats accepted; level_o=8; stop_o[1]=1 once full; req_o=1.
  - Then gnt_i=1: stop_o[1] drops the same cycle; simultaneous read and write keep level_o=8; valid_o=1 every cycle; data order preserved.
- Drain then bypass:
  - Stimulus: FIFO holding 3 entries, valid_i=0, gnt_i=1.
  - Required: 3 output beats with the stored ch_o values, level_o 3→2→1→0, req_o falls after the last read. The next source beat takes bypass.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously with level_o=5, own=2.
  - Required: level_o=0, valid_o=0, req_o=0, own=0 immediately (no clock edge needed); no stale data after release.

Source files
------------

// File: rtl/path_pkg.sv
// Shared helpers for the round-robin arbitrated path.
package path_pkg;

    localparam int MAX_CH  = 64;
    localparam int MAX_CHW = 6;

    // Next channel after own (cyclically, own excluded) with valid set; own+1 when none is valid.
    function automatic logic [MAX_CHW-1:0] rr_next(
        input logic [MAX_CHW-1:0] own,
        input logic [MAX_CH-1:0]  valid_vec,
        input int                 nch
    );
        int idx;
        logic found;
        logic [MAX_CHW-1:0] pick;
        idx = int'(own) + 1;
        if (idx >= nch) idx = idx - nch;
        pick  = MAX_CHW'(idx);
        found = 1'b0;
        for (int i = 1; i < MAX_CH; i++) begin
            if (i < nch) begin
                idx = int'(own) + i;
                if (idx >= nch) idx = idx - nch;
                if (!found && valid_vec[idx]) begin
                    pick  = MAX_CHW'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/path_fifo.sv
// Synchronous FIFO of any depth with a combinational head and registered occupancy.
module path_fifo #(
    parameter int  WIDTH = 10,
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             write_i,
    input  logic             read_i,
    output logic [WIDTH-1:0] rdata,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_write;
    logic             do_read;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o   = (level_o == LW'(DEPTH));
    assign empty_o  = (level_o == '0);
    assign do_read  = read_i & ~empty_o;
    // A write into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_write = write_i & (~full_o | read_i);
    assign rdata    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_o <= '0;
        end else begin
            if (do_write) wptr <= bump(wptr);
            if (do_read)  rptr <= bump(rptr);
            level_o <= level_o + LW'(do_write) - LW'(do_read);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/path_rr.sv
// N-channel round-robin merge onto one req/gnt port, with a FIFO and empty-FIFO bypass.
module path_rr
    import path_pkg::*;
#(
    parameter int  DWIDTH  = 8,
    parameter int  FDEPTH  = 8,
    parameter int  NCH     = 4,
    parameter int  QUANTUM = 10,
    localparam int CHW     = $clog2(NCH),
    localparam int LW      = $clog2(FDEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*DWIDTH-1:0] data_i,
    input  logic [NCH-1:0]        valid_i,
    output logic [NCH-1:0]        stop_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [DWIDTH-1:0]     data_o,
    output logic [CHW-1:0]        ch_o,
    output logic                  valid_o,
    output logic [LW-1:0]         level_o
);

    localparam int QW = $clog2(QUANTUM + 1);
    localparam int EW = DWIDTH + CHW;

    logic [CHW-1:0]    own;
    logic [CHW-1:0]    nxt;
    logic [QW-1:0]     cnt;
    logic [DWIDTH-1:0] own_data;
    logic [NCH-1:0]    others;
    logic              own_valid;
    logic              others_valid;
    logic              full;
    logic              empty;
    logic              accept;
    logic              bypass;
    logic              write;
    logic              read;
    logic [EW-1:0]     head;
    logic [LW-1:0]     level_nxt;

    assign nxt = CHW'(rr_next(MAX_CHW'(own), MAX_CH'(valid_i), NCH));

    always_comb begin
        own_valid    = valid_i[own];
        own_data     = data_i[own*DWIDTH +: DWIDTH];
        others       = valid_i;
        others[own]  = 1'b0;
        others_valid = |others;
        stop_o       = '1;
        stop_o[own]  = full & ~gnt_i;
        accept       = own_valid & ~(full & ~gnt_i);
        bypass       = empty & gnt_i & accept;
        write        = accept & ~bypass;
        read         = gnt_i & ~empty;
        level_nxt    = level_o + LW'(write) - LW'(read);
    end

    path_fifo #(
        .WIDTH (EW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wdata   ({own, own_data}),
        .write_i (write),
        .read_i  (read),
        .rdata   (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    // cnt counts accepted beats; a stalled owner keeps both its slot and its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (cnt == QW'(QUANTUM - 1)) begin
                cnt <= '0;
                if (others_valid) own <= nxt;
            end else begin
                cnt <= cnt + QW'(1);
            end
        end else if (!own_valid && others_valid) begin
            own <= nxt;
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            ch_o    <= '0;
            req_o   <= 1'b0;
        end else begin
            valid_o <= read | bypass;
            req_o   <= (|valid_i) | (level_nxt != '0);
            if (bypass) begin
                data_o <= own_data;
                ch_o   <= own;
            end else if (read) begin
                data_o <= head[DWIDTH-1:0];
                ch_o   <= head[EW-1 -: CHW];
            end
        end
    end

endmodule
